avalon_pio_gen2: RTL and testbench
==================================

// Module: avalon_pio_gen2
// PURPOSE
//  Parametrised Avalon-MM slave general-purpose I/O port. Successor to the fixed 8-bit output PIO.
//  Adds per-bit direction, synchronised input sampling, edge capture and a maskable interrupt.
//  Sits on the system interconnect alongside the DAC/ROM peripherals. Software-controlled GPIO.
// PARAMETERS
//  WIDTH       8   number of I/O bits, 1..32
//  RESET_VALUE 0   out_port value after reset, WIDTH bits
//  DIR_RESET   0   direction register value after reset; 1 = output, per bit
//  EDGE_TYPE   0   edge capture mode: 0 = rising, 1 = falling, 2 = any
//  SYNC_STAGES 2   input synchroniser depth, 2..3
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  address    in   3      register word select
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data; bits above WIDTH ignored
//  readdata   out  32     read data; combinational, zero-extended above WIDTH
//  in_port    in   WIDTH  pad input, asynchronous to clk
//  out_port   out  WIDTH  output data register
//  oe_port    out  WIDTH  per-bit output enable (= direction register)
//  irq        out  1      level interrupt, active-high
// BEHAVIOUR
//  - Register map (word address). Writes occur only when chipselect && !write_n.
//    0 DATA:     read = synchronised input; write = out_data <= wd
//    1 DIR:      read/write direction register
//    2 IRQMASK:  read/write mask
//    3 EDGECAP:  read = capture bits; write 1 clears that bit (W1C)
//    4 OUTSET:   out_data <= out_data | wd; read 0
//    5 OUTCLR:   out_data <= out_data & ~wd; read 0
//    6,7:        writes ignored; reads return 0
//  - Reset values: out_data = RESET_VALUE, dir = DIR_RESET, mask = 0, edgecap = 0, sync chain = 0, irq = 0.
//    The reset is asynchronous and overrides everything, including mid-transaction.
//  - Read latency is 0: readdata decodes address combinationally. Reads have no side effects.
//  - Input path: in_port passes through a SYNC_STAGES flip-flop chain to give sync_in.
//    prev_in is sync_in delayed by one clk.
//    Latency from a pad change to DATA readback is SYNC_STAGES cycles. Edge capture follows 1 cycle later.
//  - Edge detect per bit:
//    rise = sync_in & ~prev_in; fall = ~sync_in & prev_in; any = rise | fall; choice set by EDGE_TYPE.
//  - Edge capture is sticky: a bit is set on a detected edge and held until W1C.
//    When a detected edge and a W1C on the same bit happen in the same cycle, the set wins (no lost event).
//  - Edge detection runs regardless of the DIR bit, so output pins loop back through in_port.
//  - out_port = out_data at all times. oe_port = dir.
//  - Out-of-range writedata bits (>= WIDTH) are discarded. Readback of those bits is 0.
// CONFIGURATION
//  - Macro PIO_IRQ_EN.
//    Defined: irq is registered, irq <= |(edgecap & mask), so it asserts 1 cycle after the capture bit sets.
//    IRQMASK is read/write.
//  - Undefined: the mask register is not built. IRQMASK reads 0 and ignores writes. irq is tied 0.
//    Edge capture is still present and pollable.
// TESTING
//  - Reset: assert reset_n=0 mid-write, then release.
//    -> out_port = RESET_VALUE, oe_port = DIR_RESET, irq = 0, all registers read their reset values.
//  - Set/clear (WIDTH=8): write DATA=0xA5, OUTSET=0x0A, OUTCLR=0x81.
//    -> out_port 0xA5, then 0xAF, then 0x2E. Reads of addresses 4 and 5 return 0.
//  - Sync latency: toggle in_port[3] 0->1.
//    -> DATA bit 3 reads 1 exactly SYNC_STAGES cycles later. EDGECAP=0x08 one cycle after that (EDGE_TYPE=0).
//  - W1C collision: hold EDGECAP bit 3 set; write 0x08 to EDGECAP in the same cycle a new rising edge on bit 3 is detected.
//    -> bit 3 remains 1. A later W1C with no edge clears it to 0.
//  - IRQ (PIO_IRQ_EN): mask=0x08, then a rising edge on bit 3.
//    -> irq=1 one cycle after capture. W1C of bit 3 drops irq the following cycle. Mask=0 keeps irq=0.
//  - WIDTH=5, EDGE_TYPE=2: write DATA=0xFFFFFFFF -> out_port 0x1F, DATA readback upper bits 0.
//    A falling edge on bit 0 -> EDGECAP bit 0 = 1.

Source files
------------

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised inputs, sticky edge capture.
// Define PIO_IRQ_EN to build the interrupt mask register and the registered irq output.
module avalon_pio_gen2 #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] DIR_RESET   = 32'd0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             unused_writedata;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in_reg;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] out_data_next;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] mask_val;

  assign wd               = writedata[WIDTH-1:0];
  assign wr_en            = chipselect && !write_n;
  assign unused_writedata = ^writedata;
  assign sync_in          = sync_reg[SYNC_STAGES-1];
  assign out_port         = out_data_reg;
  assign oe_port          = dir_reg;

  always_comb begin
    rise = sync_in & ~prev_in_reg;
    fall = ~sync_in & prev_in_reg;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  // A fresh edge is OR-ed in after the W1C mask so a coincident event is never lost.
  always_comb begin
    edgecap_next = edgecap_reg;
    if (wr_en && address == ADDR_EDGECAP)
      edgecap_next = edgecap_reg & ~wd;
    edgecap_next = edgecap_next | edge_det;
  end

  always_comb begin
    out_data_next = out_data_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   out_data_next = wd;
        ADDR_OUTSET: out_data_next = out_data_reg | wd;
        ADDR_OUTCLR: out_data_next = out_data_reg & ~wd;
        default:     out_data_next = out_data_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg     <= '0;
      prev_in_reg  <= '0;
      out_data_reg <= RESET_VALUE[WIDTH-1:0];
      dir_reg      <= DIR_RESET[WIDTH-1:0];
      edgecap_reg  <= '0;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], in_port};
      prev_in_reg  <= sync_in;
      out_data_reg <= out_data_next;
      edgecap_reg  <= edgecap_next;
      if (wr_en && address == ADDR_DIR)
        dir_reg <= wd;
    end
  end

`ifdef PIO_IRQ_EN
  logic [WIDTH-1:0] mask_reg;
  logic             irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      irq_reg <= |(edgecap_reg & mask_reg);
      if (wr_en && address == ADDR_IRQMASK)
        mask_reg <= wd;
    end
  end

  assign mask_val = mask_reg;
  assign irq      = irq_reg;
`else
  assign mask_val = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = sync_in;
      ADDR_DIR:     readdata[WIDTH-1:0] = dir_reg;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_val;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Randomised and directed bench for avalon_pio_gen2; two instances (8-bit rising, 5-bit any-edge)
// are checked every cycle against a register-level model built on an input delay line.
module tb_avalon_pio_gen2;

`ifdef PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'd0;
  logic [31:0] readdata8, readdata5;
  logic [7:0]  out8, oe8;
  logic [4:0]  out5, oe5;
  logic        irq8, irq5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_pio_gen2 #(
    .WIDTH(8), .RESET_VALUE(32'h3C), .DIR_RESET(32'hF0), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata8),
    .in_port(in_port), .out_port(out8), .oe_port(oe8), .irq(irq8)
  );

  avalon_pio_gen2 #(
    .WIDTH(5), .RESET_VALUE(32'h15), .DIR_RESET(32'h0A), .EDGE_TYPE(2), .SYNC_STAGES(3)
  ) dut5 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata5),
    .in_port(in_port[4:0]), .out_port(out5), .oe_port(oe5), .irq(irq5)
  );

  // Per-instance configuration and model state (index 0 = 8-bit, 1 = 5-bit)
  logic [31:0] wm [2] = '{32'hFF, 32'h1F};
  logic [31:0] rv [2] = '{32'h3C, 32'h15};
  logic [31:0] dr [2] = '{32'hF0, 32'h0A};
  int          st [2] = '{2, 3};
  int          et [2] = '{0, 2};
  logic [31:0] m_out [2], m_dir [2], m_mask [2], m_ecap [2];
  logic        m_irq [2];
  logic [31:0] hist [2][4];   // hist[i][k] = pad value sampled k edges ago

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(int i);
    case (address)
      3'd0:    return hist[i][st[i]-1];
      3'd1:    return m_dir[i];
      3'd2:    return m_mask[i];
      3'd3:    return m_ecap[i];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = rv[i]; m_dir[i] = dr[i]; m_mask[i] = 32'd0; m_ecap[i] = 32'd0; m_irq[i] = 1'b0;
      for (int k = 0; k < 4; k++) hist[i][k] = 32'd0;
    end
  endtask

  task automatic compare_all();
    check_val("out8", {24'd0, out8}, m_out[0]);
    check_val("oe8",  {24'd0, oe8},  m_dir[0]);
    check_val("irq8", {31'd0, irq8}, {31'd0, m_irq[0]});
    check_val($sformatf("rd8_a%0d", address), readdata8, exp_rd(0));
    check_val("out5", {27'd0, out5}, m_out[1]);
    check_val("oe5",  {27'd0, oe5},  m_dir[1]);
    check_val("irq5", {31'd0, irq5}, {31'd0, m_irq[1]});
    check_val($sformatf("rd5_a%0d", address), readdata5, exp_rd(1));
  endtask

  task automatic tick();
    logic [31:0] n_out [2], n_dir [2], n_mask [2], n_ecap [2];
    logic        n_irq [2];
    logic        we;
    logic [31:0] wd, sync, prev, rise, fall, edet;
    we = chipselect && !write_n;
    for (int i = 0; i < 2; i++) begin
      wd   = writedata & wm[i];
      sync = hist[i][st[i]-1];
      prev = hist[i][st[i]];
      rise = sync & ~prev;
      fall = ~sync & prev;
      edet = (et[i] == 0) ? rise : (et[i] == 1) ? fall : (rise | fall);
      n_irq[i]  = IRQ_EN && ((m_ecap[i] & m_mask[i]) != 32'd0);
      n_ecap[i] = (m_ecap[i] & ~((we && address == 3'd3) ? wd : 32'd0)) | edet;
      n_out[i]  = m_out[i];
      n_dir[i]  = m_dir[i];
      n_mask[i] = m_mask[i];
      if (we) begin
        case (address)
          3'd0: n_out[i] = wd;
          3'd1: n_dir[i] = wd;
          3'd2: if (IRQ_EN) n_mask[i] = wd;
          3'd4: n_out[i] = m_out[i] | wd;
          3'd5: n_out[i] = m_out[i] & ~wd;
          default: ;
        endcase
      end
    end
    if (we) $display("write addr=%0d data=0x%08h in=0x%02h", address, writedata, in_port);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_out[i] = n_out[i]; m_dir[i] = n_dir[i]; m_mask[i] = n_mask[i];
      m_ecap[i] = n_ecap[i]; m_irq[i] = n_irq[i];
      for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = {24'd0, in_port} & wm[i];
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Reset asserted asynchronously in the middle of a write cycle
  task automatic do_reset();
    @(negedge clk);
    address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_out8", {24'd0, out8}, 32'h3C);
    check_val("rst_oe8",  {24'd0, oe8},  32'hF0);
    check_val("rst_irq8", {31'd0, irq8}, 32'd0);
    check_val("rst_out5", {27'd0, out5}, 32'h15);
    check_val("rst_oe5",  {27'd0, oe5},  32'h0A);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      tick();
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Set / clear sequence
    bus_wr(3'd0, 32'hA5);
    check_val("set_data", {24'd0, out8}, 32'hA5);
    bus_wr(3'd4, 32'h0A);
    check_val("set_outset", {24'd0, out8}, 32'hAF);
    check_val("rd_outset", readdata8, 32'd0);
    bus_wr(3'd5, 32'h81);
    check_val("set_outclr", {24'd0, out8}, 32'h2E);
    check_val("rd_outclr", readdata8, 32'd0);

    // Synchroniser latency and capture one cycle later
    in_port = 8'h00;
    ticks(4);
    bus_wr(3'd3, 32'hFF);
    address = 3'd0;
    in_port[3] = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      check_val($sformatf("sync_lat%0d", k), {31'd0, readdata8[3]}, (k == 2) ? 32'd1 : 32'd0);
    end
    address = 3'd3;
    tick();
    check_val("ecap_lat", readdata8, 32'h08);

    // W1C landing on the same edge as a new rising edge
    in_port[3] = 1'b0;
    ticks(4);
    in_port[3] = 1'b1;
    ticks(2);
    bus_wr(3'd3, 32'h08);
    check_val("w1c_collide", {31'd0, readdata8[3]}, 32'd1);
    ticks(2);
    bus_wr(3'd3, 32'h08);
    check_val("w1c_clear", {31'd0, readdata8[3]}, 32'd0);

    // Interrupt on masked bit 3, then with mask cleared
    bus_wr(3'd2, 32'h08);
    in_port[3] = 1'b0;
    ticks(4);
    bus_wr(3'd3, 32'hFF);
    in_port[3] = 1'b1;
    ticks(3);
    check_val("irq_pre", {31'd0, irq8}, 32'd0);
    tick();
    check_val("irq_set", {31'd0, irq8}, {31'd0, IRQ_EN});
    bus_wr(3'd3, 32'h08);
    check_val("irq_hold", {31'd0, irq8}, {31'd0, IRQ_EN});
    tick();
    check_val("irq_drop", {31'd0, irq8}, 32'd0);
    bus_wr(3'd2, 32'h00);
    in_port[3] = 1'b0;
    ticks(4);
    in_port[3] = 1'b1;
    ticks(5);
    check_val("irq_nomask", {31'd0, irq8}, 32'd0);

    // 5-bit instance: truncated write and falling-edge capture
    bus_wr(3'd0, 32'hFFFF_FFFF);
    check_val("w5_out", {27'd0, out5}, 32'h1F);
    tick();
    check_val("w5_upper", readdata5 & ~32'h1F, 32'd0);
    in_port[0] = 1'b1;
    ticks(5);
    bus_wr(3'd3, 32'hFFFF_FFFF);
    in_port[0] = 1'b0;
    ticks(4);
    check_val("w5_fall", {31'd0, readdata5[0]}, 32'd1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      tick();
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
